// File: rtl/koa_seq_pkg.sv
// Shared types and width helpers for the sequential Karatsuba significand multiplier.
package koa_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_L   = 3'd1,
        MUL_R   = 3'd2,
        MUL_M   = 3'd3,
        COMBINE = 3'd4,
        DONE    = 3'd5
    } koa_state_e;

    // Widths for the default 24-bit significand
    localparam int unsigned KOA_SW = 24;
    localparam int unsigned L      = KOA_SW - KOA_SW / 2;
    localparam int unsigned M      = L + 1;
    localparam int unsigned PW     = 2 * M;

    localparam int unsigned LAT_SEQ  = 5;
    localparam int unsigned LAT_PIPE = 8;

    // Low-half width for an arbitrary operand width (low half takes the extra bit when odd)
    function automatic int unsigned koa_low_w(input int unsigned sw);
        return sw - sw / 2;
    endfunction

endpackage

// File: rtl/koa_seq_mult_ctrl_if.sv
// Start/done handshake and operand/result bus between the FPU control FSM and the multiplier.
interface koa_seq_mult_ctrl_if #(
    parameter int unsigned SW = 24
);
    logic              start_i;
    logic [SW-1:0]     Data_A_i;
    logic [SW-1:0]     Data_B_i;
    logic              ready_o;
    logic              done_o;
    logic [2*SW-1:0]   sgf_result_o;

    modport master (
        output start_i, Data_A_i, Data_B_i,
        input  ready_o, done_o, sgf_result_o
    );

    modport slave (
        input  start_i, Data_A_i, Data_B_i,
        output ready_o, done_o, sgf_result_o
    );
endinterface

// File: rtl/koa_shared_mult.sv
// Combinational unsigned W x W -> 2W multiplier shared by all Karatsuba sub-products.
module koa_shared_mult #(
    parameter int unsigned W = 13
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);
    assign p = (2*W)'(a) * (2*W)'(b);
endmodule

// File: rtl/koa_seq_mult_ctrl.sv
// Sequential single-level Karatsuba significand multiplier on one shared multiplier.
// Define KOA_SEQ_PIPE_MUL_EN to register the multiplier output (two cycles per sub-product).
module koa_seq_mult_ctrl
    import koa_seq_pkg::*;
#(
    parameter int unsigned SW = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    koa_seq_mult_ctrl_if.slave   bus
);
    localparam int unsigned LO_W   = koa_low_w(SW);
    localparam int unsigned MUL_W  = LO_W + 1;
    localparam int unsigned PROD_W = 2 * MUL_W;
    localparam int unsigned RES_W  = 2 * SW;

    koa_state_e state_q, state_nx;

    logic [SW-1:0]     a_q, b_q;
    logic [MUL_W-1:0]  sa_q, sb_q;
    logic [PROD_W-1:0] ql_q, qr_q, qm_q;
    logic [RES_W-1:0]  res_q;
    logic              ready_q, done_q;

    logic [MUL_W-1:0]  sa_c, sb_c;
    logic [MUL_W-1:0]  mul_a, mul_b;
    logic [PROD_W-1:0] prod, prod_cap;
    logic [PROD_W-1:0] mid_c;
    logic [RES_W-1:0]  res_c;
    logic              step_c, load_c, cap_l_c, cap_r_c, cap_m_c, res_en_c;

    assign sa_c = MUL_W'(bus.Data_A_i[SW-1:LO_W]) + MUL_W'(bus.Data_A_i[LO_W-1:0]);
    assign sb_c = MUL_W'(bus.Data_B_i[SW-1:LO_W]) + MUL_W'(bus.Data_B_i[LO_W-1:0]);

    koa_shared_mult #(.W(MUL_W)) u_mult (
        .a (mul_a),
        .b (mul_b),
        .p (prod)
    );

`ifdef KOA_SEQ_PIPE_MUL_EN
    // Phase 0 registers the product, phase 1 captures it into the sub-product register
    logic [PROD_W-1:0] prod_q;
    logic              phase_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            prod_q  <= prod;
            phase_q <= (state_q == MUL_L || state_q == MUL_R || state_q == MUL_M) ? ~phase_q : 1'b0;
        end
    end

    assign prod_cap = prod_q;
    assign step_c   = phase_q;
`else
    assign prod_cap = prod;
    assign step_c   = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nx;
    end

    // Next state, multiplier operand select and register enables, all decoded from state
    always_comb begin
        state_nx = state_q;
        mul_a    = '0;
        mul_b    = '0;
        load_c   = 1'b0;
        cap_l_c  = 1'b0;
        cap_r_c  = 1'b0;
        cap_m_c  = 1'b0;
        res_en_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    load_c   = 1'b1;
                    state_nx = MUL_L;
                end
            end
            MUL_L: begin
                mul_a = MUL_W'(a_q[SW-1:LO_W]);
                mul_b = MUL_W'(b_q[SW-1:LO_W]);
                if (step_c) begin
                    cap_l_c  = 1'b1;
                    state_nx = MUL_R;
                end
            end
            MUL_R: begin
                mul_a = MUL_W'(a_q[LO_W-1:0]);
                mul_b = MUL_W'(b_q[LO_W-1:0]);
                if (step_c) begin
                    cap_r_c  = 1'b1;
                    state_nx = MUL_M;
                end
            end
            MUL_M: begin
                mul_a = sa_q;
                mul_b = sb_q;
                if (step_c) begin
                    cap_m_c  = 1'b1;
                    state_nx = COMBINE;
                end
            end
            COMBINE: begin
                res_en_c = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                if (bus.start_i) begin
                    load_c   = 1'b1;
                    state_nx = MUL_L;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Cross terms are Ah*Bl + Al*Bh, so the subtraction never goes negative
    assign mid_c = qm_q - ql_q - qr_q;
    assign res_c = (RES_W'(ql_q) << (2 * LO_W)) + (RES_W'(mid_c) << LO_W) + RES_W'(qr_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            ql_q    <= '0;
            qr_q    <= '0;
            qm_q    <= '0;
            res_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            if (load_c) begin
                a_q  <= bus.Data_A_i;
                b_q  <= bus.Data_B_i;
                sa_q <= sa_c;
                sb_q <= sb_c;
            end
            if (cap_l_c)  ql_q  <= prod_cap;
            if (cap_r_c)  qr_q  <= prod_cap;
            if (cap_m_c)  qm_q  <= prod_cap;
            if (res_en_c) res_q <= res_c;
            ready_q <= (state_nx == IDLE) || (state_nx == DONE);
            done_q  <= (state_nx == DONE);
        end
    end

    assign bus.ready_o      = ready_q;
    assign bus.done_o       = done_q;
    assign bus.sgf_result_o = res_q;

endmodule

// File: tb/tb_koa_seq_mult_ctrl.sv
// Directed self-checking bench for koa_seq_mult_ctrl at SW=24 and SW=23.
module tb_koa_seq_mult_ctrl;

`ifdef KOA_SEQ_PIPE_MUL_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 5;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    koa_seq_mult_ctrl_if #(.SW(24)) if24 ();
    koa_seq_mult_ctrl_if #(.SW(23)) if23 ();

    koa_seq_mult_ctrl #(.SW(24)) u_dut24 (.clk(clk), .rst(rst), .bus(if24));
    koa_seq_mult_ctrl #(.SW(23)) u_dut23 (.clk(clk), .rst(rst), .bus(if23));

    // One operation from IDLE; operands are scrambled right after acceptance
    task automatic op24(input logic [23:0] a, input logic [23:0] b,
                        output logic [47:0] res, output int lat, output int rdy_busy);
        @(posedge clk); #1;
        if24.Data_A_i = a; if24.Data_B_i = b; if24.start_i = 1'b1;
        @(posedge clk); #1;
        if24.start_i = 1'b0; if24.Data_A_i = ~a; if24.Data_B_i = ~b;
        lat = 1; rdy_busy = 0;
        while (!if24.done_o && lat < 20) begin
            if (if24.ready_o) rdy_busy++;
            @(posedge clk); #1; lat++;
        end
        res = if24.sgf_result_o;
    endtask

    task automatic op23(input logic [22:0] a, input logic [22:0] b,
                        output logic [45:0] res, output int lat);
        @(posedge clk); #1;
        if23.Data_A_i = a; if23.Data_B_i = b; if23.start_i = 1'b1;
        @(posedge clk); #1;
        if23.start_i = 1'b0; if23.Data_A_i = ~a; if23.Data_B_i = ~b;
        lat = 1;
        while (!if23.done_o && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        res = if23.sgf_result_o;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (if24.sgf_result_o !== 48'h0) $display("FAIL reset_res24: got %h want 0", if24.sgf_result_o); else passed++;
        checks++; if (if24.done_o !== 1'b0) $display("FAIL reset_done24: got %b want 0", if24.done_o); else passed++;
        checks++; if (if24.ready_o !== 1'b1) $display("FAIL reset_ready24: got %b want 1", if24.ready_o); else passed++;
        checks++; if (if23.sgf_result_o !== 46'h0) $display("FAIL reset_res23: got %h want 0", if23.sgf_result_o); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [47:0] r; int lat; int rb;
        op24(24'h000003, 24'h000005, r, lat, rb);
        checks++; if (r !== 48'h00000000000F) $display("FAIL basic_res: got %h want 00000000000f", r); else passed++;
        checks++; if (lat !== LAT) $display("FAIL basic_latency: got %0d want %0d", lat, LAT); else passed++;
        checks++; if (rb !== 0) $display("FAIL basic_ready_busy: ready high in %0d busy cycles, want 0", rb); else passed++;
    endtask

    task automatic test_patterns24;
        logic [47:0] r; int lat; int rb;
        op24(24'hFFFFFF, 24'hFFFFFF, r, lat, rb);
        checks++; if (r !== 48'hFFFFFE000001) $display("FAIL max24_res: got %h want fffffe000001", r); else passed++;
        checks++; if (lat !== LAT) $display("FAIL max24_latency: got %0d want %0d", lat, LAT); else passed++;
        op24(24'h000000, 24'hABCDEF, r, lat, rb);
        checks++; if (r !== 48'h000000000000) $display("FAIL zero24_res: got %h want 0", r); else passed++;
    endtask

    task automatic test_odd23;
        logic [45:0] r; int lat;
        op23(23'h7FFFFF, 23'h7FFFFF, r, lat);
        checks++; if (r !== 46'h3FFFFF000001) $display("FAIL max23_res: got %h want 3fffff000001", r); else passed++;
        checks++; if (lat !== LAT) $display("FAIL max23_latency: got %0d want %0d", lat, LAT); else passed++;
        op23(23'h400000, 23'h000002, r, lat);
        checks++; if (r !== 46'h000000800000) $display("FAIL pow23_res: got %h want 000000800000", r); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [47:0] r1, r2; int cyc; int t1, t2;
        @(posedge clk); #1;
        if24.Data_A_i = 24'h000003; if24.Data_B_i = 24'h000005; if24.start_i = 1'b1;
        @(posedge clk); #1;
        if24.Data_A_i = 24'h000010; if24.Data_B_i = 24'h000010;
        cyc = 1;
        while (!if24.done_o && cyc < 20) begin @(posedge clk); #1; cyc++; end
        t1 = cyc; r1 = if24.sgf_result_o;
        checks++; if (r1 !== 48'h00000000000F) $display("FAIL b2b_first_res: got %h want f", r1); else passed++;
        checks++; if (t1 !== LAT) $display("FAIL b2b_first_latency: got %0d want %0d", t1, LAT); else passed++;
        @(posedge clk); #1; cyc++;
        if24.start_i = 1'b0;
        while (!if24.done_o && cyc < 40) begin @(posedge clk); #1; cyc++; end
        t2 = cyc; r2 = if24.sgf_result_o;
        checks++; if (r2 !== 48'h000000000100) $display("FAIL b2b_second_res: got %h want 100", r2); else passed++;
        checks++; if (t2 - t1 !== LAT) $display("FAIL b2b_spacing: got %0d want %0d", t2 - t1, LAT); else passed++;
        @(posedge clk); #1;
        checks++; if (if24.done_o !== 1'b0) $display("FAIL b2b_done_pulse: got %b want 0", if24.done_o); else passed++;
        checks++; if (if24.ready_o !== 1'b1) $display("FAIL b2b_idle_ready: got %b want 1", if24.ready_o); else passed++;
    endtask

    task automatic test_start_busy;
        int cyc; int n_done; logic [47:0] r;
        @(posedge clk); #1;
        if24.Data_A_i = 24'h000003; if24.Data_B_i = 24'h000005; if24.start_i = 1'b1;
        @(posedge clk); #1;
        if24.start_i = 1'b0; if24.Data_A_i = 24'h000007; if24.Data_B_i = 24'h000007;
        cyc = 1;
        @(posedge clk); #1; cyc++;
        if24.start_i = 1'b1;
        @(posedge clk); #1; cyc++;
        if24.start_i = 1'b0;
        while (!if24.done_o && cyc < 20) begin @(posedge clk); #1; cyc++; end
        r = if24.sgf_result_o;
        checks++; if (r !== 48'h00000000000F) $display("FAIL busy_start_res: got %h want f", r); else passed++;
        checks++; if (cyc !== LAT) $display("FAIL busy_start_latency: got %0d want %0d", cyc, LAT); else passed++;
        n_done = 0;
        repeat (LAT + 2) begin @(posedge clk); #1; if (if24.done_o) n_done++; end
        checks++; if (n_done !== 0) $display("FAIL busy_start_queued: got %0d extra done pulses want 0", n_done); else passed++;
    endtask

    task automatic test_reset_mid;
        int n_done; logic [47:0] r; int lat; int rb;
        @(posedge clk); #1;
        if24.Data_A_i = 24'hFFFFFF; if24.Data_B_i = 24'hFFFFFF; if24.start_i = 1'b1;
        @(posedge clk); #1;
        if24.start_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (if24.sgf_result_o !== 48'h0) $display("FAIL midrst_res: got %h want 0", if24.sgf_result_o); else passed++;
        checks++; if (if24.done_o !== 1'b0) $display("FAIL midrst_done: got %b want 0", if24.done_o); else passed++;
        checks++; if (if24.ready_o !== 1'b1) $display("FAIL midrst_ready: got %b want 1", if24.ready_o); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        n_done = 0;
        repeat (LAT + 2) begin @(posedge clk); #1; if (if24.done_o) n_done++; end
        checks++; if (n_done !== 0) $display("FAIL midrst_no_done: got %0d done pulses want 0", n_done); else passed++;
        op24(24'h000003, 24'h000005, r, lat, rb);
        checks++; if (r !== 48'h00000000000F) $display("FAIL post_rst_res: got %h want f", r); else passed++;
        checks++; if (lat !== LAT) $display("FAIL post_rst_latency: got %0d want %0d", lat, LAT); else passed++;
    endtask

    initial begin
        if24.start_i = 1'b0; if24.Data_A_i = '0; if24.Data_B_i = '0;
        if23.start_i = 1'b0; if23.Data_A_i = '0; if23.Data_B_i = '0;
        test_reset();
        test_basic();
        test_patterns24();
        test_odd23();
        test_back_to_back();
        test_start_busy();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/koa_seq_mult_ctrl.md
Name: koa_seq_mult_ctrl

Overview:
- Multi-cycle sequencer for a single-level Karatsuba multiply of two SW-bit significands.
- Time-shares one (L+1)-bit combinational multiplier, with L = SW - SW/2, across the three Karatsuba sub-products: left, right, middle.
- Combines the sub-products into the 2*SW-bit significand product.
- Sits in the FPU multiply path as the area-reduced alternative to the three-multiplier single-stage KOA; start/done handshake toward the FPU control FSM.

Parameters:
- SW, 24, operand width in bits (even or odd; 23 and 24 are the supported precisions).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- start_i  input  1  request: operands valid, begin a multiply
- Data_A_i  input  SW  multiplicand, sampled only on an accepted start
- Data_B_i  input  SW  multiplier, sampled only on an accepted start
- ready_o  output  1  high when start_i will be accepted this cycle
- done_o  output  1  one-cycle pulse; sgf_result_o newly valid
- sgf_result_o  output  2*SW  product, held until the next completion

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all operand, sum and product registers = 0.
  - sgf_result_o=0, done_o=0, ready_o=1 once in IDLE.
- Split:
  - Operand X = {Xh, Xl}; Xl = X[L-1:0] (L bits), Xh = X[SW-1:L] (SW/2 bits).
  - Sums: Sa = Ah + Al, Sb = Bh + Bl, each L+1 bits, no truncation.
- Sub-products, on one shared multiplier, operands zero-extended to L+1 bits, product 2L+2 bits:
  - QL = Ah*Bh
  - QR = Al*Bl
  - QM = Sa*Sb
- Combine:
  - MID = QM - QL - QR, computed in 2L+2 bits; always non-negative.
  - RES = (QL << 2L) + (MID << L) + QR.
  - sgf_result_o = RES[2*SW-1:0]; the truncation is exact, never overflows.
- FSM states: IDLE, MUL_L, MUL_R, MUL_M, COMBINE, DONE.
  - IDLE: ready_o=1. start_i=1 -> register A, B, Sa, Sb; go to MUL_L.
  - MUL_L: multiplier muxed to (Ah,Bh); QL registered; go to MUL_R.
  - MUL_R: mux (Al,Bl); QR registered; go to MUL_M.
  - MUL_M: mux (Sa,Sb); QM registered; go to COMBINE.
  - COMBINE: RES computed and registered into sgf_result_o; go to DONE.
  - DONE: done_o=1, ready_o=1.
    - start_i=1 -> accept new operands, go to MUL_L (back-to-back).
    - otherwise go to IDLE.
- Latency: start accepted at edge N -> done_o high during cycle N+5. Throughput is one result per 5 cycles.
- start_i in MUL_L..COMBINE: ignored, not queued; ready_o=0 in those states.
- Data_A_i/Data_B_i changing after acceptance: no effect on the current operation.
- Reset mid-operation: operation discarded, no done_o; sgf_result_o returns to 0.
- Multiplier select mux is decoded from state only; no glitch requirement beyond synchronous capture.

Optional Feature:
- Macro: KOA_SEQ_PIPE_MUL_EN.
- Defined:
  - A register stage is inserted on the shared multiplier output.
  - Each MUL_x state lasts 2 cycles, controlled by a 1-bit phase counter; capture happens in the second cycle.
  - Latency becomes 8 cycles (start edge N -> done_o in cycle N+8).
  - ready_o stays low during both phases.
- Undefined: single-cycle MUL_x states, latency 5, no extra register.

Decomposition:
- Shared package koa_seq_pkg:
  - state encoding constants (IDLE..DONE, 3 bits);
  - width helper localparams L, M=L+1, PW=2*M;
  - the latency constants 5 and 8.
- One sub-module, koa_shared_mult (parameter W):
  - purely combinational W x W -> 2W unsigned multiplier;
  - instantiated once with W=L+1.
- The FSM, mux, MID/RES arithmetic and registers stay in koa_seq_mult_ctrl.

Test Plan:
- SW=24, A=0x000003, B=0x000005, start pulse -> done_o in cycle N+5, sgf_result_o=0x00000000000F, ready_o=0 for cycles N+1..N+4.
- SW=24, A=B=0xFFFFFF -> sgf_result_o=0xFFFFFE000001; A=0, B=0xABCDEF -> 0x000000000000.
- SW=23 (odd split, L=12), A=B=0x7FFFFF -> sgf_result_o=0x3FFFFF000001; A=0x400000, B=0x000002 -> 0x000000800000.
- Back-to-back, start_i held high: first op 0x000003*0x000005 = 0xF, second op 0x000010*0x000010 = 0x100 accepted in DONE -> done_o pulses 5 cycles apart.
- Mid-operation hazards:
  - start_i pulsed again during MUL_R -> ignored, result unchanged.
  - rst asserted during MUL_M -> immediately IDLE, sgf_result_o=0, no done_o.
  - Next start after reset completes normally.
- With KOA_SEQ_PIPE_MUL_EN, SW=24, A=B=0xFFFFFF -> done_o in cycle N+8, sgf_result_o=0xFFFFFE000001.
